// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes and the special register indices.
// Pure constants, no logic.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [3:0] REG_RSP  = 4'd4;
    localparam logic [3:0] REG_NONE = 4'd15;

    localparam int NUM_REGS = 15;

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports on clk.
// Writes land on the edge, so same-cycle reads see pre-write contents; M beats E on a shared index.
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [3:0] NONE_ID = REG_NONE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ra_idx,
    input  logic [3:0]  rb_idx,
    output logic [63:0] ra_dat,
    output logic [63:0] rb_dat,
    input  logic        wr_en,
    input  logic [3:0]  we_idx,
    input  logic [63:0] we_dat,
    input  logic [3:0]  wm_idx,
    input  logic [63:0] wm_dat
);

    logic [63:0] regs [0:NUM_REGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            if (we_idx != NONE_ID && we_idx < 4'(NUM_REGS)) begin
                regs[we_idx] <= we_dat;
            end
            // Issued last so it overrides the E write when both target one register.
            if (wm_idx != NONE_ID && wm_idx < 4'(NUM_REGS)) begin
                regs[wm_idx] <= wm_dat;
            end
        end
    end

    assign ra_dat = (ra_idx == NONE_ID || ra_idx >= 4'(NUM_REGS)) ? '0 : regs[ra_idx];
    assign rb_dat = (rb_idx == NONE_ID || rb_idx >= 4'(NUM_REGS)) ? '0 : regs[rb_idx];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: register selection and operand read, outputs registered (latency 1).
// stall holds all outputs, bubble loads a NOP; DECODE_WB_BYPASS_EN forwards same-cycle write-back.
module decode_stage
    import y86_pkg::*;
#(
    parameter logic [3:0] RSP_ID  = REG_RSP,
    parameter logic [3:0] NONE_ID = REG_NONE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [3:0]         icode,
    input  logic [3:0]         ifun,
    input  logic [3:0]         rA,
    input  logic [3:0]         rB,
    input  logic signed [63:0] valC,
    input  logic [63:0]        valP,
    input  logic               stall,
    input  logic               bubble,
    input  logic               wb_en,
    input  logic [3:0]         w_dstE,
    input  logic [63:0]        w_valE,
    input  logic [3:0]         w_dstM,
    input  logic [63:0]        w_valM,
    output logic               out_valid,
    output logic [3:0]         d_icode,
    output logic [3:0]         d_ifun,
    output logic [63:0]        d_valC,
    output logic [63:0]        d_valP,
    output logic [3:0]         srcA,
    output logic [3:0]         srcB,
    output logic [3:0]         dstE,
    output logic [3:0]         dstM,
    output logic [63:0]        valA,
    output logic [63:0]        valB,
    output logic               halted
);

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rd_a, rd_b, fwd_a, fwd_b;
    logic        accept;

    always_comb begin
        src_a = NONE_ID;
        src_b = NONE_ID;
        dst_e = NONE_ID;
        dst_m = NONE_ID;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
            I_RET, I_POPQ:                      src_a = RSP_ID;
            default: ;
        endcase
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP_ID;
            default: ;
        endcase
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RSP_ID;
            default: ;
        endcase
        case (icode)
            I_MRMOVQ, I_POPQ:                   dst_m = rA;
            default: ;
        endcase
    end

    y86_regfile #(
        .NONE_ID (NONE_ID)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .ra_idx (src_a),
        .rb_idx (src_b),
        .ra_dat (rd_a),
        .rb_dat (rd_b),
        .wr_en  (wb_en),
        .we_idx (w_dstE),
        .we_dat (w_valE),
        .wm_idx (w_dstM),
        .wm_dat (w_valM)
    );

    always_comb begin
        fwd_a = rd_a;
        fwd_b = rd_b;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && src_a != NONE_ID) begin
            if (w_dstM == src_a)      fwd_a = w_valM;
            else if (w_dstE == src_a) fwd_a = w_valE;
        end
        if (wb_en && src_b != NONE_ID) begin
            if (w_dstM == src_b)      fwd_b = w_valM;
            else if (w_dstE == src_b) fwd_b = w_valE;
        end
`endif
    end

    // Once halted, nothing more is accepted until reset; codes above POPQ are illegal.
    assign accept = in_valid && !halted && (icode <= I_POPQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            halted    <= 1'b0;
            d_icode   <= I_NOP;
            d_ifun    <= 4'd0;
            d_valC    <= '0;
            d_valP    <= '0;
            srcA      <= NONE_ID;
            srcB      <= NONE_ID;
            dstE      <= NONE_ID;
            dstM      <= NONE_ID;
            valA      <= '0;
            valB      <= '0;
        end else if (!stall) begin
            if (!bubble && accept) begin
                out_valid <= 1'b1;
                d_icode   <= icode;
                d_ifun    <= ifun;
                d_valC    <= valC;
                d_valP    <= valP;
                srcA      <= src_a;
                srcB      <= src_b;
                dstE      <= dst_e;
                dstM      <= dst_m;
                valA      <= fwd_a;
                valB      <= fwd_b;
                if (icode == I_HALT) halted <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                d_icode   <= I_NOP;
                d_ifun    <= 4'd0;
                srcA      <= NONE_ID;
                srcB      <= NONE_ID;
                dstE      <= NONE_ID;
                dstM      <= NONE_ID;
                valA      <= '0;
                valB      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; expected values worked out by hand.
// Build with or without DECODE_WB_BYPASS_EN; forwarding-dependent expectations follow the macro.
module tb_decode_stage;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [3:0]         icode, ifun, rA, rB;
    logic signed [63:0] valC;
    logic [63:0]        valP;
    logic               stall, bubble;
    logic               wb_en;
    logic [3:0]         w_dstE, w_dstM;
    logic [63:0]        w_valE, w_valM;
    logic               out_valid;
    logic [3:0]         d_icode, d_ifun, srcA, srcB, dstE, dstM;
    logic [63:0]        d_valC, d_valP, valA, valB;
    logic               halted;

    int n_vec = 0;
    int n_bad = 0;

    decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .valP      (valP),
        .stall     (stall),
        .bubble    (bubble),
        .wb_en     (wb_en),
        .w_dstE    (w_dstE),
        .w_valE    (w_valE),
        .w_dstM    (w_dstM),
        .w_valM    (w_valM),
        .out_valid (out_valid),
        .d_icode   (d_icode),
        .d_ifun    (d_ifun),
        .d_valC    (d_valC),
        .d_valP    (d_valP),
        .srcA      (srcA),
        .srcB      (srcB),
        .dstE      (dstE),
        .dstM      (dstM),
        .valA      (valA),
        .valB      (valB),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] c);
        in_valid = 1'b1;
        icode    = ic;
        ifun     = 4'd0;
        rA       = a;
        rB       = b;
        valC     = c;
        valP     = 64'h10;
    endtask

    task automatic wb(input logic en, input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        wb_en  = en;
        w_dstE = de;
        w_valE = ve;
        w_dstM = dm;
        w_valM = vm;
    endtask

    logic [63:0] exp_fwd9, exp_fwd3;

    initial begin
`ifdef DECODE_WB_BYPASS_EN
        exp_fwd9 = 64'd9;
        exp_fwd3 = 64'd3;
`else
        exp_fwd9 = 64'd0;
        exp_fwd3 = 64'd0;
`endif
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        in_valid = 1'b0; icode = 4'd1; ifun = 4'd0; rA = 4'hF; rB = 4'hF;
        valC = '0; valP = '0;
        wb(1'b0, 4'hF, '0, 4'hF, '0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_d_icode",   64'(d_icode),   64'd1);
        chk("rst_srcA",      64'(srcA),      64'hF);
        chk("rst_dstM",      64'(dstM),      64'hF);
        chk("rst_halted",    64'(halted),    64'd0);
        chk("rst_valA",      valA,           64'd0);
        step();
        rst = 1'b0;

        // irmovq $7, %rdi
        instr(4'd3, 4'hF, 4'd7, 64'd7);
        step();
        chk("irm_srcA",      64'(srcA),      64'hF);
        chk("irm_srcB",      64'(srcB),      64'hF);
        chk("irm_dstE",      64'(dstE),      64'd7);
        chk("irm_dstM",      64'(dstM),      64'hF);
        chk("irm_valC",      d_valC,         64'd7);
        chk("irm_valP",      d_valP,         64'h10);
        chk("irm_out_valid", 64'(out_valid), 64'd1);

        // write R6=5 while idle; idle input decodes as NOP
        in_valid = 1'b0;
        wb(1'b1, 4'd6, 64'd5, 4'hF, 64'd0);
        step();
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_d_icode",   64'(d_icode),   64'd1);
        wb(1'b0, 4'hF, '0, 4'hF, '0);
        instr(4'd6, 4'd6, 4'd7, 64'd0);
        step();
        chk("opq_valA", valA,        64'd5);
        chk("opq_srcA", 64'(srcA),   64'd6);
        chk("opq_srcB", 64'(srcB),   64'd7);
        chk("opq_dstE", 64'(dstE),   64'd7);
        chk("opq_valB", valB,        64'd0);

        // reset with a write-back pending: the write to R3 must be lost
        rst = 1'b1;
        wb(1'b1, 4'd3, 64'h55, 4'hF, 64'd0);
        step();
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;

        // same-cycle write-back R6=9 vs OPq reading R6 on both ports
        wb(1'b1, 4'hF, 64'd0, 4'd6, 64'd9);
        instr(4'd6, 4'd6, 4'd6, 64'd0);
        step();
        chk("byp_valA", valA, exp_fwd9);
        chk("byp_valB", valB, exp_fwd9);
        wb(1'b0, 4'hF, '0, 4'hF, '0);
        instr(4'd6, 4'd6, 4'd3, 64'd0);
        step();
        chk("post_byp_valA", valA, 64'd9);
        chk("rst_drop_wb_R3", valB, 64'd0);

        // popq %rsp with E and M both writing R4: M value must win
        wb(1'b1, 4'd4, 64'd8, 4'd4, 64'd3);
        instr(4'd11, 4'd4, 4'hF, 64'd0);
        step();
        chk("pop_srcA", 64'(srcA), 64'd4);
        chk("pop_srcB", 64'(srcB), 64'd4);
        chk("pop_dstE", 64'(dstE), 64'd4);
        chk("pop_dstM", 64'(dstM), 64'd4);
        chk("pop_valA", valA,      exp_fwd3);
        wb(1'b0, 4'hF, '0, 4'hF, '0);
        instr(4'd6, 4'd4, 4'hF, 64'd0);
        step();
        chk("R4_after_pop", valA, 64'd3);

        // stall + bubble: outputs hold, register write still happens
        stall = 1'b1; bubble = 1'b1;
        wb(1'b1, 4'd2, 64'h22, 4'hF, 64'd0);
        instr(4'd3, 4'hF, 4'd2, 64'h99);
        step();
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_d_icode",   64'(d_icode),   64'd6);
        chk("stall_srcA",      64'(srcA),      64'd4);
        chk("stall_valA",      valA,           64'd3);
        stall = 1'b0;
        wb(1'b0, 4'hF, '0, 4'hF, '0);
        step();
        chk("bub_out_valid", 64'(out_valid), 64'd0);
        chk("bub_d_icode",   64'(d_icode),   64'd1);
        chk("bub_srcA",      64'(srcA),      64'hF);
        chk("bub_dstE",      64'(dstE),      64'hF);
        chk("bub_valA",      valA,           64'd0);
        bubble = 1'b0;
        instr(4'd6, 4'd2, 4'hF, 64'd0);
        step();
        chk("stall_wb_R2", valA, 64'h22);

        // illegal icode
        instr(4'd12, 4'd1, 4'd2, 64'd0);
        step();
        chk("bad_out_valid", 64'(out_valid), 64'd0);
        chk("bad_d_icode",   64'(d_icode),   64'd1);
        chk("bad_dstE",      64'(dstE),      64'hF);

        // halt then further instructions ignored
        instr(4'd0, 4'hF, 4'hF, 64'd0);
        step();
        chk("halt_halted",    64'(halted),    64'd1);
        chk("halt_out_valid", 64'(out_valid), 64'd1);
        chk("halt_d_icode",   64'(d_icode),   64'd0);
        instr(4'd1, 4'hF, 4'hF, 64'd0);
        step();
        chk("hlt_nop_out_valid", 64'(out_valid), 64'd0);
        chk("hlt_nop_halted",    64'(halted),    64'd1);
        instr(4'd3, 4'hF, 4'd5, 64'd1);
        step();
        chk("hlt_irm_out_valid", 64'(out_valid), 64'd0);
        chk("hlt_irm_dstE",      64'(dstE),      64'hF);
        rst = 1'b1;
        #1;
        chk("rst_clr_halted", 64'(halted), 64'd0);
        step();
        rst = 1'b0;
        instr(4'd3, 4'hF, 4'd5, 64'd1);
        step();
        chk("after_rst_out_valid", 64'(out_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
